cm0_dap_mem_ap: RTL

- Debugger-side memory-access initiator that drives the core debug SLV port (slv_addr/size/trans/wdata/write out; slv_rdata/ready/resp in).
- Converts single AP register accesses from the debug port front end into SLV bus transactions.
- Holds the CSW, TAR and DRW registers, auto-increments TAR, and tracks sticky bus errors.
- Sits between the DP/JTAG-SW front end and the core debug subsystem, in the dclk domain.

---
 rtl/cm0_dap_pkg.sv | 34 +++
 rtl/cm0_dap_tar_inc.sv | 33 +++
 rtl/cm0_dap_mem_ap.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cm0_dap_pkg.sv
// Shared encodings for the CM0 DAP memory access port: FSM states, AP register
// indices, CSW field positions and SLV bus codes.
package cm0_dap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } ap_state_e;

  localparam logic [3:0] IDX_CSW = 4'h0;
  localparam logic [3:0] IDX_TAR = 4'h1;
  localparam logic [3:0] IDX_DRW = 4'h3;
  localparam logic [3:0] IDX_IDR = 4'hF;

  localparam int CSW_SIZE_LSB = 0;
  localparam int CSW_INC_LSB  = 4;
  localparam int CSW_TRINPROG = 6;
  localparam int CSW_DEVEN    = 7;
  localparam int CSW_STICKY   = 8;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam logic [1:0] INC_SINGLE = 2'b01;

endpackage

// File: rtl/cm0_dap_tar_inc.sv
// TAR helper: size-aligned bus address and the auto-incremented TAR, which
// wraps inside a 2^WRAP_BITS-byte block while the upper bits stay fixed.
module cm0_dap_tar_inc
  import cm0_dap_pkg::*;
#(
  parameter int WRAP_BITS = 10
) (
  input  logic [31:0] tar,
  input  logic [1:0]  size,
  output logic [31:0] addr_aligned,
  output logic [31:0] tar_next
);

  logic [WRAP_BITS-1:0] step;
  logic [WRAP_BITS-1:0] low_next;

  always_comb begin
    addr_aligned = tar;
    step         = WRAP_BITS'(4);
    case (size)
      SIZE_BYTE: step = WRAP_BITS'(1);
      SIZE_HALF: begin
        addr_aligned[0] = 1'b0;
        step            = WRAP_BITS'(2);
      end
      SIZE_WORD: addr_aligned[1:0] = 2'b00;
      default: ;
    endcase
    low_next = tar[WRAP_BITS-1:0] + step;
    tar_next = {tar[31:WRAP_BITS], low_next};
  end

endmodule

// File: rtl/cm0_dap_mem_ap.sv
// CM0 DAP memory access port: turns AP register accesses into SLV transfers.
// Optional banked data registers BD0..BD3 are enabled by CM0_DAP_BANKED_DATA_EN.
module cm0_dap_mem_ap
  import cm0_dap_pkg::*;
#(
  parameter logic [31:0] AP_IDR    = 32'h0477_0001,
  parameter logic [31:0] TAR_RST   = 32'h0000_0000,
  parameter int          WRAP_BITS = 10
) (
  input  logic        dclk,
  input  logic        dbg_reset,
  input  logic        ap_req_i,
  input  logic [3:0]  ap_addr_i,
  input  logic        ap_write_i,
  input  logic [31:0] ap_wdata_i,
  output logic        ap_ready_o,
  output logic        ap_done_o,
  output logic [31:0] ap_rdata_o,
  output logic        ap_err_o,
  output logic [31:0] slv_addr_o,
  output logic [1:0]  slv_size_o,
  output logic [1:0]  slv_trans_o,
  output logic [31:0] slv_wdata_o,
  output logic        slv_write_o,
  input  logic [31:0] slv_rdata_i,
  input  logic        slv_ready_i,
  input  logic        slv_resp_i
);

  ap_state_e   state, state_nxt;
  logic [1:0]  csw_size, csw_inc;
  logic        sticky;
  logic [31:0] tar, drw;
  logic [3:0]  req_idx;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        accept, is_bus, bus_blocked, trinprog;
  logic [31:0] addr_aligned, tar_next, bus_addr, csw_val, reg_rdata;

  cm0_dap_tar_inc #(.WRAP_BITS(WRAP_BITS)) u_tar_inc (
    .tar          (tar),
    .size         (csw_size),
    .addr_aligned (addr_aligned),
    .tar_next     (tar_next)
  );

`ifdef CM0_DAP_BANKED_DATA_EN
  assign is_bus   = (ap_addr_i == IDX_DRW) || (ap_addr_i[3:2] == 2'b01);
  assign bus_addr = (ap_addr_i[3:2] == 2'b01) ? {tar[31:4], ap_addr_i[1:0], 2'b00}
                                              : addr_aligned;
`else
  assign is_bus   = (ap_addr_i == IDX_DRW);
  assign bus_addr = addr_aligned;
`endif

  assign accept      = ap_req_i && (state == ST_IDLE);
  assign bus_blocked = sticky || (csw_size == SIZE_BAD);
  assign trinprog    = (state == ST_ADDR) || (state == ST_DATA);

  assign ap_ready_o  = (state == ST_IDLE);
  assign ap_done_o   = (state == ST_RESP);
  assign ap_rdata_o  = resp_rdata;
  assign ap_err_o    = resp_err;
  assign slv_trans_o = (state == ST_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;

  always_comb begin
    csw_val                          = '0;
    csw_val[CSW_SIZE_LSB +: 2]       = csw_size;
    csw_val[CSW_INC_LSB +: 2]        = csw_inc;
    csw_val[CSW_TRINPROG]            = trinprog;
    csw_val[CSW_DEVEN]               = 1'b1;
    csw_val[CSW_STICKY]              = sticky;
    case (req_idx)
      IDX_CSW: reg_rdata = csw_val;
      IDX_TAR: reg_rdata = tar;
      IDX_IDR: reg_rdata = AP_IDR;
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (dbg_reset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!is_bus)         state_nxt = ST_REG;
          else if (bus_blocked) state_nxt = ST_RESP;
          else                 state_nxt = ST_ADDR;
        end
      end
      ST_REG:  state_nxt = ST_RESP;
      ST_ADDR: if (slv_ready_i) state_nxt = ST_DATA;
      ST_DATA: if (slv_ready_i) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (dbg_reset) begin
      csw_size    <= SIZE_WORD;
      csw_inc     <= 2'b00;
      sticky      <= 1'b0;
      tar         <= TAR_RST;
      drw         <= '0;
      req_idx     <= '0;
      req_write   <= 1'b0;
      req_wdata   <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      slv_addr_o  <= '0;
      slv_size_o  <= SIZE_WORD;
      slv_wdata_o <= '0;
      slv_write_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_idx   <= ap_addr_i;
            req_write <= ap_write_i;
            req_wdata <= ap_wdata_i;
            if (is_bus && bus_blocked) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (is_bus) begin
              slv_addr_o  <= bus_addr;
              slv_size_o  <= csw_size;
              slv_write_o <= ap_write_i;
              if (ap_write_i) drw <= ap_wdata_i;
            end
          end
        end
        ST_REG: begin
          resp_err   <= 1'b0;
          resp_rdata <= reg_rdata;
          if (req_write) begin
            case (req_idx)
              IDX_CSW: begin
                csw_size <= req_wdata[CSW_SIZE_LSB +: 2];
                csw_inc  <= req_wdata[CSW_INC_LSB +: 2];
                if (req_wdata[CSW_STICKY]) sticky <= 1'b0;
              end
              IDX_TAR: tar <= req_wdata;
              default: ;
            endcase
          end
        end
        ST_ADDR: begin
          if (slv_ready_i && req_write) slv_wdata_o <= drw;
        end
        ST_DATA: begin
          if (slv_ready_i) begin
            if (slv_resp_i) begin
              sticky     <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              resp_err   <= 1'b0;
              resp_rdata <= req_write ? 32'h0 : slv_rdata_i;
              // banked registers never move TAR
              if (csw_inc == INC_SINGLE && req_idx == IDX_DRW) tar <= tar_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
